// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/stall controller.
package hazard_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         MD_CNT_W = 4;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic reg_match(
        input logic       en,
        input logic [4:0] dst,
        input logic [4:0] src
    );
        return en && (dst == src) && (src != REG_ZERO);
    endfunction

endpackage

// File: rtl/muldiv_busy_tracker.sv
// Tracks HI/LO occupancy of the multi-cycle mult/div unit.
module muldiv_busy_tracker
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy
);

    localparam logic [MD_CNT_W-1:0] CNT_LOAD = MD_CNT_W'(MD_LATENCY - 1);

    md_state_e           state_q, state_d;
    logic [MD_CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    // Back-to-back op is accepted on the final busy edge.
                    if (start) begin
                        cnt_d = CNT_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == BUSY);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush/bubble control for hazards forwarding cannot cover,
// plus saturating stall and flush performance counters.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_Rs,
    input  logic [4:0]       IF_ID_Rt,
    input  logic             IF_ID_UsesRt,
    input  logic             IF_ID_Branch,
    input  logic             IF_ID_BranchTaken,
    input  logic             IF_ID_Jump,
    input  logic             IF_ID_ReadHiLo,
    input  logic             IF_ID_MulDiv,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_RegWrite,
    input  logic [4:0]       ID_EX_RegWriteAddr,
    input  logic             ID_EX_MulDiv,
    input  logic             EX_MEM_MemRead,
    input  logic [4:0]       EX_MEM_RegWriteAddr,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    logic match_e;
    logic match_m;
    logic lu_haz;
    logic br_haz;
    logic md_haz;
    logic stall;
    logic flush_req;
    logic flush_ev;

    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    muldiv_busy_tracker #(
        .MD_LATENCY(MD_LATENCY)
    ) u_md (
        .clk  (clk),
        .rst_n(rst_n),
        .start(ID_EX_MulDiv),
        .busy (md_busy)
    );

    always_comb begin
        match_e = reg_match(ID_EX_RegWrite, ID_EX_RegWriteAddr, IF_ID_Rs)
                | reg_match(ID_EX_RegWrite & IF_ID_UsesRt,
                            ID_EX_RegWriteAddr, IF_ID_Rt);
        match_m = reg_match(EX_MEM_MemRead, EX_MEM_RegWriteAddr, IF_ID_Rs)
                | reg_match(EX_MEM_MemRead & IF_ID_UsesRt,
                            EX_MEM_RegWriteAddr, IF_ID_Rt);
        lu_haz    = ID_EX_MemRead & match_e;
        br_haz    = IF_ID_Branch & (match_e | match_m);
        md_haz    = md_busy & (IF_ID_ReadHiLo | IF_ID_MulDiv);
        stall     = lu_haz | br_haz | md_haz;
        flush_req = IF_ID_Jump | (IF_ID_Branch & IF_ID_BranchTaken);
        // A stalled branch's compare result is not yet trustworthy.
        flush_ev  = rst_n & ~stall & flush_req;
    end

    always_comb begin
        PC_Write    = rst_n & ~stall;
        IF_ID_Write = rst_n & ~stall;
        ID_EX_Flush = ~rst_n | stall;
        IF_ID_Flush = ~rst_n | flush_ev;
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        if (flush_ev && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule
